// File: rtl/sample_frame_collector.sv
// sample_frame_collector
//
// Packs a serial stream of WIDTH-bit samples into frames of SAMPLES samples
// and hands each frame to the FFT input-reorder stage as a parallel array.
// Two frame banks alternate roles. One bank fills from the stream while the
// other holds a finished frame for the consumer. This lets the stream run at
// one sample per clock as long as each frame is taken within SAMPLES cycles.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset; clears banks, flags and counter
//   flush        drops the partially filled frame; same-cycle sample is ignored
//   in_sample    serial input sample
//   in_valid     in_sample is valid
//   in_ready     collector can accept a sample this cycle
//   frame_out    frame array presented to the consumer; [0] is the oldest sample
//   frame_valid  frame_out holds a complete frame
//   frame_ready  consumer takes frame_out this cycle
//   frame_count  number of frames handed off, wraps modulo 2^16
module sample_frame_collector #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] frame_out [SAMPLES],
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [15:0]      frame_count
);
  localparam int CNT_W = $clog2(SAMPLES);

  logic [WIDTH-1:0] bank_q [2][SAMPLES];
  logic [WIDTH-1:0] bank_d [2][SAMPLES];
  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] wr_idx_q, wr_idx_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             accept;
  logic             handoff;

  // The write bank is only blocked when it still holds an unconsumed frame,
  // which happens exactly when both banks are full.
  assign in_ready    = !reset && !flush && !bank_full_q[wr_bank_q];
  assign frame_valid = bank_full_q[rd_bank_q];
  assign frame_count = frame_count_q;
  assign accept      = in_valid && in_ready;
  assign handoff     = frame_valid && frame_ready;

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      frame_out[i] = bank_q[rd_bank_q][i];
    end
  end

  // A completing write and a handoff can share an edge. They never touch the
  // same bank: a write needs its bank empty, and a handoff needs its bank full.
  always_comb begin
    bank_d        = bank_q;
    bank_full_d   = bank_full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_idx_d      = wr_idx_q;
    frame_count_d = frame_count_q;

    if (flush) begin
      wr_idx_d = '0;
    end else if (accept) begin
      bank_d[wr_bank_q][wr_idx_q] = in_sample;
      if (wr_idx_q == CNT_W'(SAMPLES - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_idx_d               = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    if (handoff) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
      frame_count_d          = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SAMPLES; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      bank_full_q   <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      frame_count_q <= '0;
    end else begin
      bank_q        <= bank_d;
      bank_full_q   <= bank_full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule
